// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int N     = 32;
    localparam int R     = 5;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Issue-side bundle: operation request, HI/LO state and the regfile write-back request.
interface muldiv_if;
    import muldiv_pkg::*;

    logic         start;
    op_t          op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         mf_req;
    logic         mf_sel;
    logic [R-1:0] mf_dst;
    logic         busy;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
    logic         wb_we;
    logic [R-1:0] wb_wa;
    logic [N-1:0] wb_wd;

    modport master (
        output start, op, a, b, mf_req, mf_sel, mf_dst,
        input  busy, hi, lo, dz, wb_we, wb_wa, wb_wd
    );

    modport slave (
        input  start, op, a, b, mf_req, mf_sel, mf_dst,
        output busy, hi, lo, dz, wb_we, wb_wa, wb_wd
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers and
// a one-cycle move-from write request toward the register file.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    state_t           state;
    op_t              op_q;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   acc;
    logic [N-1:0]     mag_d;
    logic [N-1:0]     a_q;
    logic             neg_res;
    logic             neg_rem;
    logic [N-1:0]     hi_q, lo_q;
    logic             dz_q;
    logic             wb_we_q;
    logic [R-1:0]     wb_wa_q;
    logic [N-1:0]     wb_wd_q;

    logic             signed_in;
    logic             is_mul_in;
    logic             is_mul_q;
    logic [N-1:0]     mag_a_in, mag_b_in;
    logic [N:0]       mul_sum;
    logic [N:0]       div_shift;
    logic             div_ge;
    logic [N-1:0]     div_rem;

    assign signed_in = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign is_mul_in = (bus.op == OP_MULTU) || (bus.op == OP_MULT);
    assign is_mul_q  = (op_q == OP_MULTU) || (op_q == OP_MULT);
    assign mag_a_in  = (signed_in && bus.a[N-1]) ? -bus.a : bus.a;
    assign mag_b_in  = (signed_in && bus.b[N-1]) ? -bus.b : bus.b;

    // Multiply keeps {partial product, remaining multiplier} in acc; divide keeps
    // {remainder, remaining dividend / growing quotient}. The remainder gets one
    // guard bit only for the compare, since the restored value always fits in N bits.
    assign mul_sum   = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? mag_d : '0)};
    assign div_shift = {acc[2*N-1:N], acc[N-1]};
    assign div_ge    = div_shift >= {1'b0, mag_d};
    assign div_rem   = div_ge ? (div_shift[N-1:0] - mag_d) : div_shift[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_MULTU;
            cnt     <= '0;
            acc     <= '0;
            mag_d   <= '0;
            a_q     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            wb_we_q <= 1'b0;
            wb_wa_q <= '0;
            wb_wd_q <= '0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees pre-edge values of
            // hi/lo/acc, which is what lets a same-cycle mf_req return pre-op HI/LO.
            wb_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mf_req) begin
                        wb_we_q <= (bus.mf_dst != '0);
                        wb_wa_q <= bus.mf_dst;
                        wb_wd_q <= bus.mf_sel ? hi_q : lo_q;
                    end
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_q     <= bus.a;
                        mag_d   <= is_mul_in ? mag_a_in : mag_b_in;
                        acc     <= {{N{1'b0}}, (is_mul_in ? mag_b_in : mag_a_in)};
                        neg_res <= signed_in && (bus.a[N-1] ^ bus.b[N-1]);
                        neg_rem <= signed_in && bus.a[N-1];
                        dz_q    <= 1'b0;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc <= is_mul_q ? {mul_sum, acc[N-1:1]}
                                    : {div_rem, acc[N-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N-1)) state <= FIX;
                end
                FIX: begin
                    if (is_mul_q) begin
                        {hi_q, lo_q} <= neg_res ? -acc : acc;
                    end else if (mag_d == '0) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                        dz_q <= 1'b1;
                    end else begin
                        lo_q <= neg_res ? -acc[N-1:0]   : acc[N-1:0];
                        hi_q <= neg_rem ? -acc[2*N-1:N] : acc[2*N-1:N];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.dz    = dz_q;
    assign bus.wb_we = wb_we_q;
    assign bus.wb_wa = wb_wa_q;
    assign bus.wb_wd = wb_wd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    muldiv_if m ();
    muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(m));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} computed with 64-bit integer arithmetic.
    function automatic logic [63:0] ref_model(input op_t op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            OP_MULTU: return ua * ub;
            OP_MULT:  return sa * sb;
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = ua / ub; r = ua % ub;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic do_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input bit mf_same);
        int          cyc;
        logic [63:0] r;
        logic [31:0] old_hi;
        r = ref_model(op, a, b);
        old_hi = exp_hi;
        @(negedge clk);
        m.start = 1'b1; m.op = op; m.a = a; m.b = b;
        if (mf_same) begin m.mf_req = 1'b1; m.mf_sel = 1'b1; m.mf_dst = 5'd9; end
        @(posedge clk); #1;
        m.start = 1'b0; m.mf_req = 1'b0; m.a = $urandom; m.b = $urandom;
        if (mf_same) begin
            check("mf_same_we", m.wb_we, 1);
            check("mf_same_wa", m.wb_wa, 9);
            check("mf_same_wd", m.wb_wd, old_hi);
        end
        cyc = 0;
        while (m.busy && cyc < 100) begin
            cyc++;
            if (poke && cyc == 5) begin
                m.start = 1'b1; m.op = OP_MULTU; m.a = 32'h0BAD; m.b = 32'h0F00;
                m.mf_req = 1'b1; m.mf_sel = 1'b1; m.mf_dst = 5'd7;
            end
            @(posedge clk); #1;
            if (poke && cyc == 5) begin
                m.start = 1'b0; m.mf_req = 1'b0;
                check("mf_busy_we", m.wb_we, 0);
            end
        end
        check("busy_cycles", cyc, 33);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        exp_dz = (op == OP_DIVU || op == OP_DIV) && (b == 0);
        check("hi", m.hi, exp_hi);
        check("lo", m.lo, exp_lo);
        check("dz", m.dz, exp_dz);
    endtask

    task automatic do_mf(input bit sel, input logic [4:0] dst);
        @(negedge clk);
        m.mf_req = 1'b1; m.mf_sel = sel; m.mf_dst = dst;
        @(posedge clk); #1;
        m.mf_req = 1'b0;
        check("mf_we", m.wb_we, dst != 0);
        if (dst != 0) begin
            check("mf_wa", m.wb_wa, dst);
            check("mf_wd", m.wb_wd, sel ? exp_hi : exp_lo);
        end
        @(posedge clk); #1;
        check("mf_we_drop", m.wb_we, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            3:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        m.start = 1'b0; m.op = OP_MULTU; m.a = '0; m.b = '0;
        m.mf_req = 1'b0; m.mf_sel = 1'b0; m.mf_dst = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", m.busy, 0);
        check("rst_hi", m.hi, 0);
        check("rst_lo", m.lo, 0);
        check("rst_dz", m.dz, 0);
        check("rst_we", m.wb_we, 0);
        check("rst_wa", m.wb_wa, 0);
        check("rst_wd", m.wb_wd, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_hi_const", m.hi, 32'hFFFF_FFFE);
        check("multu_lo_const", m.lo, 32'h0000_0001);
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0);
        check("mult_lo_const", m.lo, 32'hFFFF_FFEB);
        do_op(OP_DIV, -32'd7, 32'd2, 0, 0);
        check("div_lo_const", m.lo, 32'hFFFF_FFFD);
        do_op(OP_DIVU, 32'd100, 32'd7, 0, 0);
        check("divu_hi_const", m.hi, 32'd2);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf_lo_const", m.lo, 32'h8000_0000);
        do_op(OP_DIVU, 32'h1234, 32'd0, 0, 0);
        check("dz_set_const", m.dz, 1);
        do_op(OP_MULTU, 32'd2, 32'd3, 0, 0);
        check("dz_clear_lo_const", m.lo, 32'd6);

        do_op(OP_MULT, 32'hDEAD_BEEF, 32'h0000_1234, 1, 0);
        do_mf(1'b1, 5'd5);
        do_mf(1'b0, 5'd0);
        do_op(OP_DIV, 32'hFFFF_FF00, 32'd9, 0, 1);

        // Reset in the middle of a running multiply.
        @(negedge clk);
        m.start = 1'b1; m.op = OP_MULT; m.a = 32'd5; m.b = -32'd3;
        @(posedge clk); #1;
        m.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_busy", m.busy, 0);
        check("midrun_hi", m.hi, 0);
        check("midrun_lo", m.lo, 0);
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_mf(1'b0, 5'd4);

        for (int i = 0; i < 40; i++) begin
            do_op(op_t'($urandom_range(0, 3)), rnd_val(), rnd_val(), 0, 0);
            do_mf(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers, the execute-side neighbour of the register file. It takes operands from the regfile read ports (rd1/rd2), runs a 32-iteration shift-add multiply or restoring divide, and holds the 2n-bit result in HI/LO. It returns HI or LO to the regfile through a one-cycle write request shaped like the regfile write port (we3/wa3/wd3).

## Interface
- n, 32, datapath width
- r, 5, register address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin operation; accepted only when busy=0
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  n  multiplicand / dividend (from rd1)
- b  in  n  multiplier / divisor (from rd2)
- mf_req  in  1  move-from request; accepted only when busy=0
- mf_sel  in  1  0 = LO, 1 = HI
- mf_dst  in  r  destination register
- busy  out  1  operation in flight; issue stage stalls on it
- hi, lo  out  n  result registers
- dz  out  1  last accepted divide had b=0
- wb_we, wb_wa, wb_wd  out  1/r/n  registered write request to regfile

## Operation
- FSM states: IDLE, RUN, FIX. busy = (state != IDLE).
- IDLE + start: latch op; latch |a|, |b| (two's-complement magnitude for MULT/DIV, raw for unsigned); record result sign(s); counter=0; go to RUN.
- RUN: one iteration per cycle, counter 0..n-1. Multiply: 2n-bit accumulator, shift-add. Divide: restoring, n-bit remainder plus one guard bit. After iteration n-1, go to FIX.
- FIX: apply sign correction, write hi/lo, go to IDLE.
  - MULT: {hi,lo} = negated product if operand signs differ.
  - DIV: quotient truncates toward zero (negate if signs differ); remainder takes the dividend's sign.
- Divide by zero: iterations run as normal. FIX forces hi = a (as latched), lo = all ones, and sets dz. dz clears on the next accepted start.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the magnitude arithmetic truncated to n bits; no trap.
- start while busy: ignored, no effect.
- mf_req while busy: ignored. wb_we stays 0.
- mf_req accepted: next cycle wb_we=1, wb_wa=mf_dst, wb_wd=(mf_sel ? hi : lo), all for exactly one cycle. If mf_dst=0, wb_we stays 0.
- start and mf_req in the same idle cycle: both accepted. mf returns the pre-operation hi/lo.

## Timing
- start sampled at edge 0, then RUN at edges 1..n, then FIX at edge n+1.
- busy is high for exactly n+1 cycles (33 at default n).
- hi/lo are valid, and a new start or mf_req is accepted, from the cycle after edge n+1.
- Move-from latency is 1 cycle, request edge to wb_* valid.
- Reset (async assert, any state including mid-RUN):
  - state=IDLE, busy=0
  - hi=lo=0, dz=0
  - wb_we=0, wb_wa=0, wb_wd=0
  - counter and accumulator cleared; the in-flight operation is discarded.
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.

## Structure
- Package muldiv_pkg holds the op_t enum (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV) and the state_t enum (IDLE, RUN, FIX).
- Single module; no sub-module. Negate/abs are inline expressions.
- Counter width is $clog2(n).

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV cases:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 -> lo=14, hi=2.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF, dz=1; next MULTU 2*3 -> dz=0, lo=6.
- Move-from handshake:
  - mf_req during busy -> wb_we stays 0.
  - After done, mf_sel=1, mf_dst=5 -> next cycle wb_we=1, wb_wa=5, wb_wd=hi, then wb_we=0.
  - mf_dst=0 -> wb_we=0.
- Reset and start-while-busy:
  - Pulse rst_n low at cycle 10 of a MULT -> busy=0, hi=lo=0 immediately.
  - start pulsed while busy -> hi/lo match the first operation only.
